// File: rtl/dyt_ifid_buffer.sv
// rtl/dyt_ifid_buffer.sv - fetch-to-decode 2-entry skid buffer with flush, halt and stall counting
module dyt_ifid_buffer #(
    parameter int                WORD_W    = 32,
    parameter logic [WORD_W-1:0] NOP_INSN  = 32'h00000013,
    parameter logic [WORD_W-1:0] HALT_INSN = 32'hFFFFFFFF,
    parameter int                STALL_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_valid_i,
    input  logic [WORD_W-1:0]  fetch_instruction_i,
    input  logic [WORD_W-1:0]  fetch_pc_i,
    output logic               fetch_ready_o,
    output logic               ifid_valid_o,
    output logic [WORD_W-1:0]  ifid_instruction_o,
    output logic [WORD_W-1:0]  ifid_pc_o,
    input  logic               decode_ready_i,
    input  logic               flush_i,
    output logic               halt_o,
    output logic [STALL_W-1:0] stall_cnt_o
);

    logic [1:0]        count;
    logic [WORD_W-1:0] e0_insn;
    logic [WORD_W-1:0] e0_pc;
    logic [WORD_W-1:0] e1_insn;
    logic [WORD_W-1:0] e1_pc;
    logic              push;
    logic              pop;

    // Handshake and head presentation; ready is built from registers only so decode
    // backpressure never reaches fetch combinationally.
    always_comb begin
        fetch_ready_o      = !rst && !halt_o && (count != 2'd2);
        ifid_valid_o       = !rst && (count != 2'd0);
        ifid_instruction_o = ifid_valid_o ? e0_insn : NOP_INSN;
        ifid_pc_o          = ifid_valid_o ? e0_pc : '0;
        push               = fetch_valid_i && fetch_ready_o;
        pop                = ifid_valid_o && decode_ready_i;
    end

    // Entry storage, occupancy, sticky halt and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= 2'd0;
            e0_insn     <= '0;
            e0_pc       <= '0;
            e1_insn     <= '0;
            e1_pc       <= '0;
            halt_o      <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (fetch_valid_i && !fetch_ready_o && (stall_cnt_o != {STALL_W{1'b1}}))
                stall_cnt_o <= stall_cnt_o + 1'b1;

            if (flush_i) begin
                // Squash everything, including this cycle's push and pop.
                count <= 2'd0;
            end else begin
                if (pop && (e0_insn == HALT_INSN))
                    halt_o <= 1'b1;

                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) begin
                            e0_insn <= fetch_instruction_i;
                            e0_pc   <= fetch_pc_i;
                        end else begin
                            e1_insn <= fetch_instruction_i;
                            e1_pc   <= fetch_pc_i;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        e0_insn <= e1_insn;
                        e0_pc   <= e1_pc;
                        count   <= count - 2'd1;
                    end
                    2'b11: begin
                        // Only reachable with one entry: the new word replaces the head.
                        e0_insn <= fetch_instruction_i;
                        e0_pc   <= fetch_pc_i;
                    end
                    default: ;
                endcase
            end
        end
    end

    a_count_max: assert property (@(posedge clk) disable iff (rst) count <= 2'd2);
    a_nop_idle:  assert property (@(posedge clk) !ifid_valid_o |-> ifid_instruction_o == NOP_INSN);

endmodule

// File: tb/tb_dyt_ifid_buffer.sv
// tb/tb_dyt_ifid_buffer.sv - scoreboard bench for dyt_ifid_buffer
module tb_dyt_ifid_buffer;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid_i;
    logic [31:0] fetch_instruction_i;
    logic [31:0] fetch_pc_i;
    logic        decode_ready_i;
    logic        flush_i;

    logic        fetch_ready_o;
    logic        ifid_valid_o;
    logic [31:0] ifid_instruction_o;
    logic [31:0] ifid_pc_o;
    logic        halt_o;
    logic [15:0] stall_cnt_o;

    logic        s_fetch_ready;
    logic        s_ifid_valid;
    logic [31:0] s_ifid_instruction;
    logic [31:0] s_ifid_pc;
    logic        s_halt;
    logic [3:0]  s_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    dyt_ifid_buffer dut (
        .clk(clk), .rst(rst),
        .fetch_valid_i(fetch_valid_i), .fetch_instruction_i(fetch_instruction_i),
        .fetch_pc_i(fetch_pc_i), .fetch_ready_o(fetch_ready_o),
        .ifid_valid_o(ifid_valid_o), .ifid_instruction_o(ifid_instruction_o),
        .ifid_pc_o(ifid_pc_o), .decode_ready_i(decode_ready_i),
        .flush_i(flush_i), .halt_o(halt_o), .stall_cnt_o(stall_cnt_o)
    );

    dyt_ifid_buffer #(.STALL_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .fetch_valid_i(fetch_valid_i), .fetch_instruction_i(fetch_instruction_i),
        .fetch_pc_i(fetch_pc_i), .fetch_ready_o(s_fetch_ready),
        .ifid_valid_o(s_ifid_valid), .ifid_instruction_o(s_ifid_instruction),
        .ifid_pc_o(s_ifid_pc), .decode_ready_i(decode_ready_i),
        .flush_i(flush_i), .halt_o(s_halt), .stall_cnt_o(s_stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] insn, input logic [31:0] pc, input bit expect_pop);
        fetch_valid_i       = 1'b1;
        fetch_instruction_i = insn;
        fetch_pc_i          = pc;
        if (expect_pop) sb.push_back({insn, pc});
    endtask

    // Monitor: every head consumed by decode (outside reset and flush) must match the scoreboard.
    always @(negedge clk) begin
        if (!rst && ifid_valid_o && decode_ready_i && !flush_i) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_pop: got %h_%h expected none", ifid_instruction_o, ifid_pc_o);
            end else begin
                chk("sb_pop", {ifid_instruction_o, ifid_pc_o}, sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; fetch_valid_i = 1'b0; fetch_instruction_i = '0; fetch_pc_i = '0;
        decode_ready_i = 1'b0; flush_i = 1'b0;

        // Reset
        step(); step();
        chk("rst_ready", 64'(fetch_ready_o), 64'd0);
        chk("rst_valid", 64'(ifid_valid_o), 64'd0);
        chk("rst_insn",  64'(ifid_instruction_o), 64'(NOP));
        chk("rst_halt",  64'(halt_o), 64'd0);
        chk("rst_stall", 64'(stall_cnt_o), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(fetch_ready_o), 64'd1);

        // Stream
        decode_ready_i = 1'b1;
        drive(32'h00100093, 32'h0, 1'b1); step();
        chk("stream_head0", {32'(ifid_valid_o), ifid_pc_o}, {32'd1, 32'h0});
        drive(32'h00200113, 32'h4, 1'b1); step();
        chk("stream_ready", 64'(fetch_ready_o), 64'd1);
        drive(32'h00300193, 32'h8, 1'b1); step();
        chk("stream_head2", {32'(ifid_valid_o), ifid_pc_o}, {32'd1, 32'h8});
        fetch_valid_i = 1'b0; step();
        chk("stream_drained", 64'(ifid_valid_o), 64'd0);

        // Backpressure
        decode_ready_i = 1'b0;
        drive(32'h10000013, 32'h100, 1'b1); step();
        drive(32'h10400013, 32'h104, 1'b1); step();
        chk("bp_full_ready", 64'(fetch_ready_o), 64'd0);
        drive(32'h10800013, 32'h108, 1'b0);
        step(); step(); step();
        chk("bp_stall_cnt", 64'(stall_cnt_o), 64'd3);
        fetch_valid_i = 1'b0; decode_ready_i = 1'b1;
        step(); step();
        chk("bp_drained", 64'(ifid_valid_o), 64'd0);

        // Flush
        decode_ready_i = 1'b0;
        drive(32'h20000013, 32'h200, 1'b0); step();
        drive(32'h20400013, 32'h204, 1'b0); step();
        drive(32'h30000013, 32'h300, 1'b0); flush_i = 1'b1; step();
        flush_i = 1'b0;
        chk("flush_valid", 64'(ifid_valid_o), 64'd0);
        chk("flush_ready", 64'(fetch_ready_o), 64'd1);
        chk("flush_stall_cnt", 64'(stall_cnt_o), 64'd4);
        drive(32'h40000013, 32'h400, 1'b1); step();
        chk("flush_new_head", {32'(ifid_valid_o), ifid_pc_o}, {32'd1, 32'h400});
        fetch_valid_i = 1'b0; decode_ready_i = 1'b1; step();

        // Halt
        drive(NOP, 32'h20, 1'b1); step();
        drive(HALT, 32'h24, 1'b1); step();
        chk("halt_before", 64'(halt_o), 64'd0);
        drive(32'h00000033, 32'h28, 1'b1); step();
        chk("halt_set", 64'(halt_o), 64'd1);
        chk("halt_ready", 64'(fetch_ready_o), 64'd0);
        fetch_valid_i = 1'b0; step(); step(); step();
        chk("halt_sticky", {32'(halt_o), 32'(fetch_ready_o)}, {32'd1, 32'd0});
        chk("halt_drained", 64'(ifid_valid_o), 64'd0);
        rst = 1'b1; step(); rst = 1'b0; #1;
        chk("halt_cleared_rst", {32'(halt_o), 32'(fetch_ready_o)}, {32'd0, 32'd1});
        decode_ready_i = 1'b0;
        drive(HALT, 32'h30, 1'b0); step();
        fetch_valid_i = 1'b0; flush_i = 1'b1; decode_ready_i = 1'b1; step();
        flush_i = 1'b0; decode_ready_i = 1'b0;
        chk("halt_flush_valid", 64'(ifid_valid_o), 64'd0);
        step();
        chk("halt_flush_no_halt", 64'(halt_o), 64'd0);

        // Saturation
        rst = 1'b1; step(); rst = 1'b0;
        drive(32'h50000013, 32'h500, 1'b0); step();
        drive(32'h50400013, 32'h504, 1'b0); step();
        drive(32'h50800013, 32'h508, 1'b0);
        for (int i = 0; i < 20; i++) step();
        chk("sat_stall_w4", 64'(s_stall_cnt), 64'hF);
        chk("sat_stall_w16", 64'(stall_cnt_o), 64'd20);
        fetch_valid_i = 1'b0; flush_i = 1'b1; step();
        flush_i = 1'b0; step();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
